// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two
// requesters, with per-port credit counting and 2-entry response FIFOs.
module alu_share_arbiter #(
  parameter logic LAST_GNT_RST = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_op1_i,
  input  logic [31:0] req0_op2_i,
  input  logic [3:0]  req0_ctrl_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_op1_i,
  input  logic [31:0] req1_op2_i,
  input  logic [3:0]  req1_ctrl_i,
  output logic        rsp0_valid_o,
  input  logic        rsp0_ready_i,
  output logic [31:0] rsp0_data_o,
  output logic        rsp0_zero_o,
  output logic        rsp1_valid_o,
  input  logic        rsp1_ready_i,
  output logic [31:0] rsp1_data_o,
  output logic        rsp1_zero_o,
  output logic [31:0] alu_op1_o,
  output logic [31:0] alu_op2_o,
  output logic [3:0]  alu_ctrl_o,
  input  logic [31:0] alu_data_i,
  input  logic        alu_zero_i
);
  logic [1:0]  req_valid, rsp_ready, elig, gnt, rsp_valid, pop, rsp_zero;
  logic [31:0] rsp_data [2];
  logic        last_gnt, iss_valid, iss_id;
  logic [31:0] iss_op1, iss_op2;
  logic [3:0]  iss_ctrl;
  assign req_valid = {req1_valid_i, req0_valid_i};
  assign rsp_ready = {rsp1_ready_i, rsp0_ready_i};
  assign pop = rsp_valid & rsp_ready;
  // on a tie the port that did not win last time gets the grant
  always_comb begin
    gnt[0] = elig[0] & (~elig[1] | last_gnt);
    gnt[1] = elig[1] & (~elig[0] | ~last_gnt);
  end
  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      iss_valid <= 1'b0;
      iss_id    <= 1'b0;
      iss_op1   <= '0;
      iss_op2   <= '0;
      iss_ctrl  <= '0;
      last_gnt  <= LAST_GNT_RST;
    end else begin
      iss_valid <= |gnt;
      if (|gnt) begin
        iss_op1  <= gnt[1] ? req1_op1_i : req0_op1_i;
        iss_op2  <= gnt[1] ? req1_op2_i : req0_op2_i;
        iss_ctrl <= gnt[1] ? req1_ctrl_i : req0_ctrl_i;
        iss_id   <= gnt[1];
        last_gnt <= gnt[1];
      end
    end
  end
  assign alu_op1_o  = iss_op1;
  assign alu_op2_o  = iss_op2;
  assign alu_ctrl_o = iss_ctrl;
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [1:0]  cnt, fcnt;
    logic        wp, rp, push;
    logic [32:0] mem [2];
    assign push         = iss_valid && iss_id == 1'(p);
    assign elig[p]      = req_valid[p] && cnt != 2'd2;
    assign rsp_valid[p] = fcnt != 2'd0;
    assign {rsp_data[p], rsp_zero[p]} = mem[rp];
    // cnt covers issue stage plus FIFO, so the FIFO can never overflow
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        cnt    <= '0;
        fcnt   <= '0;
        wp     <= 1'b0;
        rp     <= 1'b0;
        mem[0] <= '0;
        mem[1] <= '0;
      end else begin
        cnt  <= cnt + 2'(gnt[p]) - 2'(pop[p]);
        fcnt <= fcnt + 2'(push) - 2'(pop[p]);
        if (push) begin
          mem[wp] <= {alu_data_i, alu_zero_i};
          wp      <= ~wp;
        end
        if (pop[p]) rp <= ~rp;
      end
    end
  end
  assign rsp0_valid_o = rsp_valid[0];
  assign rsp1_valid_o = rsp_valid[1];
  assign rsp0_data_o  = rsp_data[0];
  assign rsp1_data_o  = rsp_data[1];
  assign rsp0_zero_o  = rsp_zero[0];
  assign rsp1_zero_o  = rsp_zero[1];
endmodule
